// File: rtl/ucca_config_regs.sv
// rtl/ucca_config_regs.sv - UCCA region bounds, lock, violation log and CPU reset pulse
module ucca_config_regs #(
  parameter logic [15:0] BASE_ADDR    = 16'h0160,
  parameter int          RESET_CYCLES = 8
) (
  input  logic        clk,
  input  logic        system_reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        return_reset,
  input  logic        stack_reset,
  output logic [15:0] ucc0_min,
  output logic [15:0] ucc0_max,
  output logic [15:0] ucc1_min,
  output logic [15:0] ucc1_max,
  output logic [1:0]  region_en,
  output logic        locked,
  output logic        cpu_reset
);

  // Word address of the first register; the window is six words long.
  localparam logic [13:0] BASE_WORD = BASE_ADDR[14:1];

  // Pulse counter only needs to hold RESET_CYCLES-1.
  localparam int            CW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RESET_CYCLES - 1);

  localparam logic [2:0] OFF_UCC0_MIN = 3'd0;
  localparam logic [2:0] OFF_UCC0_MAX = 3'd1;
  localparam logic [2:0] OFF_UCC1_MIN = 3'd2;
  localparam logic [2:0] OFF_UCC1_MAX = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;

  typedef enum logic {
    S_IDLE,
    S_ASSERT
  } state_t;

  // Register state
  logic [15:0] ucc0_min_q, ucc0_min_d;
  logic [15:0] ucc0_max_q, ucc0_max_d;
  logic [15:0] ucc1_min_q, ucc1_min_d;
  logic [15:0] ucc1_max_q, ucc1_max_d;
  logic [1:0]  en_q, en_d;
  logic        locked_q, locked_d;
  logic        ret_viol_q, ret_viol_d;
  logic        stack_viol_q, stack_viol_d;
  logic [7:0]  vcount_q, vcount_d;
  logic        viol_q, viol_d;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Address decode
  logic [13:0] word_off;
  logic        in_win;
  logic [2:0]  offset;
  logic        rd_en;
  logic        wr_en;
  logic        wr_cfg;
  logic        wr_status;
  logic        viol;
  logic        viol_edge;

  assign word_off  = per_addr - BASE_WORD;
  assign in_win    = (per_addr >= BASE_WORD) && (word_off < 14'd6);
  assign offset    = word_off[2:0];
  assign rd_en     = per_en && (per_we == 2'b00) && in_win;
  assign wr_en     = per_en && (per_we != 2'b00) && in_win;
  // Locking freezes bounds and CTRL; STATUS stays writable so logs can be acknowledged.
  assign wr_cfg    = wr_en && !locked_q;
  assign wr_status = wr_en && (offset == OFF_STATUS) && per_we[0];

  assign viol      = return_reset | stack_reset;
  assign viol_edge = viol && !viol_q;

  // Merge the selected byte lanes of a write into the previous register value.
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                              input logic [15:0] new_val,
                                              input logic [1:0]  lanes);
    merge_lanes[15:8] = lanes[1] ? new_val[15:8] : old_val[15:8];
    merge_lanes[7:0]  = lanes[0] ? new_val[7:0]  : old_val[7:0];
  endfunction

  // Next-state for bounds, CTRL, lock and the violation log.
  always_comb begin
    ucc0_min_d   = ucc0_min_q;
    ucc0_max_d   = ucc0_max_q;
    ucc1_min_d   = ucc1_min_q;
    ucc1_max_d   = ucc1_max_q;
    en_d         = en_q;
    locked_d     = locked_q;
    ret_viol_d   = ret_viol_q;
    stack_viol_d = stack_viol_q;
    vcount_d     = vcount_q;
    viol_d       = viol;

    if (wr_cfg) begin
      case (offset)
        OFF_UCC0_MIN: ucc0_min_d = merge_lanes(ucc0_min_q, per_din, per_we);
        OFF_UCC0_MAX: ucc0_max_d = merge_lanes(ucc0_max_q, per_din, per_we);
        OFF_UCC1_MIN: ucc1_min_d = merge_lanes(ucc1_min_q, per_din, per_we);
        OFF_UCC1_MAX: ucc1_max_d = merge_lanes(ucc1_max_q, per_din, per_we);
        OFF_CTRL: begin
          if (per_we[0]) begin
            en_d = per_din[1:0];
          end
          // LOCK is sticky: a 0 written here never unlocks.
          if (per_we[1] && per_din[15]) begin
            locked_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Acknowledge first, then apply any new event so a same-cycle edge survives.
    if (wr_status) begin
      if (per_din[0]) ret_viol_d   = 1'b0;
      if (per_din[1]) stack_viol_d = 1'b0;
      if (per_din[2]) vcount_d     = 8'd0;
    end

    if (viol_edge) begin
      if (return_reset) ret_viol_d   = 1'b1;
      if (stack_reset)  stack_viol_d = 1'b1;
      if (vcount_d != 8'hFF) vcount_d = vcount_d + 8'd1;
    end
  end

  // Reset pulse FSM: a fixed-length pulse that later edges cannot stretch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cpu_reset = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (viol_edge) begin
          state_d = S_ASSERT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_ASSERT: begin
        cpu_reset = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; only the system reset clears them, never cpu_reset.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      ucc0_min_q   <= 16'h0000;
      ucc0_max_q   <= 16'h0000;
      ucc1_min_q   <= 16'h0000;
      ucc1_max_q   <= 16'h0000;
      en_q         <= 2'b00;
      locked_q     <= 1'b0;
      ret_viol_q   <= 1'b0;
      stack_viol_q <= 1'b0;
      vcount_q     <= 8'd0;
      viol_q       <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
    end else begin
      ucc0_min_q   <= ucc0_min_d;
      ucc0_max_q   <= ucc0_max_d;
      ucc1_min_q   <= ucc1_min_d;
      ucc1_max_q   <= ucc1_max_d;
      en_q         <= en_d;
      locked_q     <= locked_d;
      ret_viol_q   <= ret_viol_d;
      stack_viol_q <= stack_viol_d;
      vcount_q     <= vcount_d;
      viol_q       <= viol_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  // Combinational read-back, zero when not a valid in-window read.
  always_comb begin
    per_dout = 16'h0000;
    if (rd_en) begin
      case (offset)
        OFF_UCC0_MIN: per_dout = ucc0_min_q;
        OFF_UCC0_MAX: per_dout = ucc0_max_q;
        OFF_UCC1_MIN: per_dout = ucc1_min_q;
        OFF_UCC1_MAX: per_dout = ucc1_max_q;
        OFF_CTRL:     per_dout = {locked_q, 13'd0, en_q};
        OFF_STATUS:   per_dout = {vcount_q, 6'd0, stack_viol_q, ret_viol_q};
        default:      per_dout = 16'h0000;
      endcase
    end
  end

  // An inverted range is never enabled, whatever EN says.
  assign region_en[0] = en_q[0] && (ucc0_min_q <= ucc0_max_q);
  assign region_en[1] = en_q[1] && (ucc1_min_q <= ucc1_max_q);

  assign ucc0_min = ucc0_min_q;
  assign ucc0_max = ucc0_max_q;
  assign ucc1_min = ucc1_min_q;
  assign ucc1_max = ucc1_max_q;
  assign locked   = locked_q;

endmodule

// File: doc/ucca_config_regs.md
Name: ucca_config_regs

Overview:
- Memory-mapped configuration and response block for UCCA, sitting on the openMSP430 peripheral bus.
- Holds the lockable bounds and enable bits for two UCC regions. These drive the region monitors' ucc_min/ucc_max inputs.
- Consumes the monitors' return/stack violation flags. It logs the cause, counts the events, and drives a fixed-length CPU reset pulse.
- Its own registers clear only on system_reset_n. Violation logs therefore survive the reset pulse it issues.

Parameters:
- BASE_ADDR, 16'h0160: byte base address of the register window, which spans 6 words up to BASE_ADDR+16'h000B.
- RESET_CYCLES, 8: cycles for which cpu_reset is held high per accepted violation; minimum 1.

Ports:
- clk  in  1  system clock
- system_reset_n  in  1  asynchronous active-low reset
- per_addr  in  14  peripheral word address (byte address >> 1)
- per_din  in  16  write data
- per_en  in  1  peripheral access strobe
- per_we  in  2  byte write enables; [0] is the low byte, [1] is the high byte
- per_dout  out  16  read data
- return_reset  in  1  return-integrity violation from the region monitor
- stack_reset  in  1  stack-protection violation from the region monitor
- ucc0_min, ucc0_max, ucc1_min, ucc1_max  out  16 each  region bounds
- region_en  out  2  per-region enable, already qualified for validity
- locked  out  1  configuration lock state
- cpu_reset  out  1  active-high reset request to the CPU core

Behaviour:
- Register map, as word offsets from BASE_ADDR/2:
  - 0: UCC0_MIN
  - 1: UCC0_MAX
  - 2: UCC1_MIN
  - 3: UCC1_MAX
  - 4: CTRL, with [0] EN0, [1] EN1, [15] LOCK, other bits read 0
  - 5: STATUS, with [0] RET_VIOL, [1] STACK_VIOL, [15:8] VCOUNT, other bits read 0
- Reset (system_reset_n low, asynchronous):
  - All bounds, CTRL and STATUS are 0.
  - locked=0, cpu_reset=0, region_en=0, and the FSM is in IDLE.
- Reads:
  - per_dout is combinational and valid in the same cycle.
  - It carries the selected register when per_en=1, per_we=0 and the address is in the window. Otherwise it is 16'h0000.
- Writes:
  - Taken on the clk rising edge when per_en=1, per_we!=0 and the address is in the window.
  - Byte lanes are applied independently.
  - Out-of-window accesses are ignored.
- Lock:
  - Writing CTRL with LOCK=1 (high lane) sets locked. The EN bits in that same write also take effect.
  - While locked=1, writes to offsets 0-4 are ignored. LOCK is cleared only by system_reset_n.
- region_en[i] = EN[i] AND (uccN_min <= uccN_max), unsigned compare. An inverted range is never enabled.
- STATUS writes are always allowed, whether locked or not, and are low lane only:
  - Bits [0] and [1] are write-1-to-clear.
  - Writing 1 to bit [2] clears VCOUNT.
  - Setting a log bit has priority over clearing it in the same cycle.
- Violation edge: viol = return_reset | stack_reset, registered to detect the 0->1 edge.
  - On an edge, set RET_VIOL and/or STACK_VIOL according to which inputs are high in that cycle.
  - VCOUNT increments by 1 and saturates at 255.
  - A level held high counts once.
- Reset FSM:
  - IDLE: a violation edge moves to ASSERT and loads the counter with RESET_CYCLES-1.
  - ASSERT: cpu_reset=1. The counter decrements each cycle, and the FSM returns to IDLE after the cycle in which it reads 0. cpu_reset is therefore high for exactly RESET_CYCLES cycles, starting the cycle after the edge.
  - A violation edge during ASSERT is logged and counted but does not extend or restart the pulse.
  - An edge in the first cycle back in IDLE starts a new pulse.
- Bounds, CTRL and locked are not changed by cpu_reset. Only system_reset_n alters them.
- Asserting system_reset_n mid-pulse immediately drops cpu_reset and returns the FSM to IDLE.

Test Plan:
- Program UCC0_MIN=16'hE000, UCC0_MAX=16'hE0FF, CTRL=16'h0001 -> ucc0 outputs match, region_en=2'b01, and read-back returns the same values the same cycle.
- Write CTRL=16'h8003, then UCC0_MIN=16'h1234 -> locked=1, UCC0_MIN unchanged at 16'hE000, region_en=2'b11 only if UCC1 bounds are valid (0<=0 passes, so 2'b11).
- UCC1_MIN=16'h0200, UCC1_MAX=16'h0100, EN1=1 -> region_en[1]=0.
- Pulse return_reset high for 3 cycles -> STATUS=16'h0101, and cpu_reset is high for exactly 8 cycles starting one cycle after the rise. A stack_reset edge at pulse cycle 4 -> STATUS=16'h0203|bit0, so 16'h0203, and the pulse is still 8 cycles total.
- 300 separate violation edges -> VCOUNT=255. Write STATUS=16'h0007 -> STATUS=0. A simultaneous edge and W1C write -> the edge's bit stays set.
- Drop system_reset_n during ASSERT -> cpu_reset=0 immediately and all registers read 0 afterwards.
